// File: rtl/rsa_job_sequencer.sv
// Key/message sequencer in front of the RSA control datapath: issues reset pulses, waits on finish flags, buffers results.
// Optional watchdog on every wait phase is enabled by defining RSA_SEQ_TIMEOUT_EN.
module rsa_job_sequencer #(
    parameter int WIDTH = 128
`ifdef RSA_SEQ_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_key_valid,
    output logic                 o_key_ready,
    input  logic [WIDTH-1:0]     i_p_in,
    input  logic [WIDTH-1:0]     i_q_in,
    input  logic                 i_encrypt_decrypt_in,
    input  logic                 i_msg_valid,
    output logic                 o_msg_ready,
    input  logic [2*WIDTH-1:0]   i_msg_data,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic [2*WIDTH-1:0]   o_res_data,
    output logic [WIDTH-1:0]     o_p,
    output logic [WIDTH-1:0]     o_q,
    output logic                 o_encrypt_decrypt,
    output logic [2*WIDTH-1:0]   o_msg_in,
    output logic                 o_reset_inverter,
    output logic                 o_reset_mod_exp,
    input  logic                 i_inverter_finish,
    input  logic                 i_mod_exp_finish,
    input  logic [2*WIDTH-1:0]   i_msg_out,
    output logic                 o_key_loaded,
    output logic                 o_busy,
    output logic                 o_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY_RST,
        S_KEY_WAIT,
        S_READY,
        S_MSG_RST,
        S_MSG_WAIT,
        S_OUT
`ifdef RSA_SEQ_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    state_t               r_state;
    logic                 r_key_ready;
    logic                 r_msg_ready;
    logic                 r_res_valid;
    logic [2*WIDTH-1:0]   r_res_data;
    logic [WIDTH-1:0]     r_p;
    logic [WIDTH-1:0]     r_q;
    logic                 r_dir;
    logic [2*WIDTH-1:0]   r_msg_in;
    logic                 r_rst_inv;
    logic                 r_rst_mexp;
    logic                 r_key_loaded;
    logic                 r_busy;
    logic                 r_blank;
`ifdef RSA_SEQ_TIMEOUT_EN
    logic [31:0]          r_wait_cnt;
    logic                 r_error;
`endif

    logic w_key_hs;
    logic w_msg_rdy;
    logic w_msg_hs;
    logic w_res_hs;

    // A pending key suppresses msg_ready in the same cycle so the key always wins.
    assign w_key_hs  = r_key_ready & i_key_valid;
    assign w_msg_rdy = r_msg_ready & ~i_key_valid;
    assign w_msg_hs  = w_msg_rdy & i_msg_valid;
    assign w_res_hs  = r_res_valid & i_res_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_key_ready  <= 1'b0;
            r_msg_ready  <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_p          <= '0;
            r_q          <= '0;
            r_dir        <= 1'b0;
            r_msg_in     <= '0;
            r_rst_inv    <= 1'b0;
            r_rst_mexp   <= 1'b0;
            r_key_loaded <= 1'b0;
            r_busy       <= 1'b0;
            r_blank      <= 1'b0;
`ifdef RSA_SEQ_TIMEOUT_EN
            r_wait_cnt   <= '0;
            r_error      <= 1'b0;
`endif
        end else begin
            r_rst_inv  <= 1'b0;
            r_rst_mexp <= 1'b0;
            case (r_state)
                S_IDLE, S_READY: begin
                    if (w_key_hs) begin
                        r_p          <= i_p_in;
                        r_q          <= i_q_in;
                        r_dir        <= i_encrypt_decrypt_in;
                        r_rst_inv    <= 1'b1;
                        r_key_loaded <= 1'b0;
                        r_key_ready  <= 1'b0;
                        r_msg_ready  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_KEY_RST;
                    end else if (w_msg_hs) begin
                        r_msg_in     <= i_msg_data;
                        r_rst_mexp   <= 1'b1;
                        r_key_ready  <= 1'b0;
                        r_msg_ready  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_MSG_RST;
                    end else begin
                        r_key_ready  <= 1'b1;
                    end
                end
                S_KEY_RST: begin
                    r_blank <= 1'b1;
                    r_state <= S_KEY_WAIT;
`ifdef RSA_SEQ_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                S_KEY_WAIT: begin
                    if (!r_blank && i_inverter_finish) begin
                        r_key_loaded <= 1'b1;
                        r_key_ready  <= 1'b1;
                        r_msg_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_READY;
                    end else begin
                        r_blank <= 1'b0;
`ifdef RSA_SEQ_TIMEOUT_EN
                        if (r_wait_cnt + 32'd1 == TIMEOUT_CYCLES) begin
                            r_error <= 1'b1;
                            r_state <= S_ERR;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 32'd1;
                        end
`endif
                    end
                end
                S_MSG_RST: begin
                    r_blank <= 1'b1;
                    r_state <= S_MSG_WAIT;
`ifdef RSA_SEQ_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                S_MSG_WAIT: begin
                    if (!r_blank && i_mod_exp_finish) begin
                        r_res_data  <= i_msg_out;
                        r_res_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_blank <= 1'b0;
`ifdef RSA_SEQ_TIMEOUT_EN
                        if (r_wait_cnt + 32'd1 == TIMEOUT_CYCLES) begin
                            r_error <= 1'b1;
                            r_state <= S_ERR;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 32'd1;
                        end
`endif
                    end
                end
                S_OUT: begin
                    if (w_res_hs) begin
                        r_res_valid <= 1'b0;
                        r_key_ready <= 1'b1;
                        r_msg_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_READY;
                    end
                end
`ifdef RSA_SEQ_TIMEOUT_EN
                S_ERR: begin
                    r_key_ready <= 1'b0;
                    r_msg_ready <= 1'b0;
                    r_res_valid <= 1'b0;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_key_ready       = r_key_ready;
    assign o_msg_ready       = w_msg_rdy;
    assign o_res_valid       = r_res_valid;
    assign o_res_data        = r_res_data;
    assign o_p               = r_p;
    assign o_q               = r_q;
    assign o_encrypt_decrypt = r_dir;
    assign o_msg_in          = r_msg_in;
    assign o_reset_inverter  = r_rst_inv;
    assign o_reset_mod_exp   = r_rst_mexp;
    assign o_key_loaded      = r_key_loaded;
    assign o_busy            = r_busy;
`ifdef RSA_SEQ_TIMEOUT_EN
    assign o_error           = r_error;
`else
    assign o_error           = 1'b0;
`endif

endmodule

// File: doc/rsa_job_sequencer.md
# rsa_job_sequencer

Upstream front-end for the RSA `control` datapath. It accepts a key (p, q, direction) and a stream of messages over valid/ready handshakes. It drives `control`'s `reset_inverter` / `reset_mod_exp` pulse protocol, waits for the finish flags, and returns each `msg_out` on a buffered result handshake. This replaces hand-sequenced resets with a reusable FSM.

## Interface
- WIDTH, 128, prime width; message/result width is 2*WIDTH
- TIMEOUT_CYCLES, 65535, watchdog limit per wait phase (used only with RSA_SEQ_TIMEOUT_EN)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- key_valid / key_ready  in/out  1  key handshake
- p_in, q_in  in  WIDTH  primes, captured on key handshake
- encrypt_decrypt_in  in  1  direction, captured on key handshake
- msg_valid / msg_ready  in/out  1  message handshake
- msg_data  in  2*WIDTH  message, captured on msg handshake
- res_valid / res_ready  out/in  1  result handshake
- res_data  out  2*WIDTH  registered result
- p, q  out  WIDTH  to control; registered key
- encrypt_decrypt  out  1  to control
- msg_in  out  2*WIDTH  to control; registered message
- reset_inverter, reset_mod_exp  out  1  one-cycle pulses to control
- inverter_finish, mod_exp_finish, msg_out  in  1/1/2*WIDTH  from control
- key_loaded  out  1  inverter completed for current key
- busy  out  1  state not IDLE/READY
- error  out  1  sticky watchdog flag (0 when macro absent)

## Operation
- States: IDLE, KEY_RST, KEY_WAIT, READY, MSG_RST, MSG_WAIT, OUT, ERR (ERR only with macro).
- IDLE: key_ready=1, msg_ready=0. key handshake -> latch p/q/dir, -> KEY_RST.
- KEY_RST: reset_inverter=1 for exactly one cycle, clear key_loaded, -> KEY_WAIT.
- KEY_WAIT: first cycle is blanking (finish ignored). Afterwards inverter_finish=1 -> key_loaded=1, -> READY.
- READY: key_ready=1, msg_ready=1. If key_valid and msg_valid are both high, the key wins: msg_ready is driven 0 that cycle and only the key is accepted -> KEY_RST. A msg handshake latches msg_in -> MSG_RST.
- MSG_RST: reset_mod_exp=1 for one cycle, -> MSG_WAIT.
- MSG_WAIT: one blanking cycle, then mod_exp_finish=1 -> res_data<=msg_out, res_valid=1, -> OUT.
- OUT: hold res_data/res_valid until res_ready=1, then -> READY. key_ready=msg_ready=0.
- p, q, encrypt_decrypt and msg_in are stable from latch until the next handshake of their kind. They never change during a wait phase.
- All handshakes complete on a cycle where both valid and ready are high.

## Timing
- Reset values: state=IDLE, all outputs 0 (p, q, msg_in, res_data zeroed); key_ready=1 once reset deasserts.
- Reset mid-operation: abort immediately to IDLE. No pulse is emitted, and a pending result is discarded.
- Key latency: handshake at cycle N -> reset_inverter high at N+1 -> finish sampled from N+3 -> READY the cycle after finish.
- Message latency: handshake at N -> reset_mod_exp at N+1 -> result valid the cycle after mod_exp_finish is sampled, minimum N+4.
- res_ready held high in OUT gives a back-to-back message accept no earlier than the cycle after the result handshake.
- A finish flag already high in the blanking cycle is ignored. A finish high in the first sampled cycle is accepted.

## Configuration
- RSA_SEQ_TIMEOUT_EN defined: a 32-bit counter clears on entry to KEY_WAIT/MSG_WAIT and increments each wait cycle. Reaching TIMEOUT_CYCLES -> ERR, error=1, all ready=0, res_valid=0. Only reset exits ERR.
- Not defined: no counter, no ERR state, error tied 0, waits are unbounded.

## Test plan
- Key load: p=113680897410347, q=7999808077935876437321, dir=0; stub inverter finishes 5 cycles after pulse -> one reset_inverter pulse, key_loaded=1 at cycle 7 after handshake.
- Message: msg_data=256'h00262d00000000000000000000000000; stub returns msg_in^{2*WIDTH{1'b1}} after 20 cycles -> res_data equals that value, res_valid held across 3 cycles of res_ready=0.
- Priority: key_valid and msg_valid high together in READY -> key accepted, msg_ready=0, reset_inverter pulses and reset_mod_exp does not.
- Stale finish: mod_exp_finish stuck 1 through the pulse -> ignored in the blanking cycle, result captured in the first sampled cycle.
- Reset mid-MSG_WAIT: assert reset asynchronously -> all outputs 0 the same cycle, state IDLE, no res_valid.
- With RSA_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, stub never finishes -> error=1 after 8 wait cycles, msg_ready=0 until reset.
